// File: rtl/program_loader.sv
// Serial-link program loader: receives framed instruction words over a byte
// handshake, writes them to instruction memory and releases the CPU on success.
module program_loader #(
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int PC_WIDTH          = 8,
  parameter int TIMEOUT_CYCLES    = 1000
) (
  input  logic                         clock,
  input  logic                         isResetN,
  input  logic [7:0]                   byteData,
  input  logic                         byteValid,
  output logic                         byteReady,
  output logic                         writeEnable,
  output logic [PC_WIDTH-1:0]          writeAddress,
  output logic [INSTRUCTION_WIDTH-1:0] writeData,
  output logic                         cpuReset,
  output logic                         loadDone,
  output logic                         loadError
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] COUNT = 3'd1;
  localparam logic [2:0] HIGH  = 3'd2;
  localparam logic [2:0] LOW   = 3'd3;
  localparam logic [2:0] CHECK = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  localparam logic [2:0] ERROR = 3'd6;

  localparam logic [7:0] START = 8'hA5;

  // One extra bit so a full 2^PC_WIDTH-word program is representable.
  localparam int IW = PC_WIDTH + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [31:0] MAX_WORDS = 32'd1 << PC_WIDTH;
  localparam logic [TW-1:0] TLIMIT = TW'(TIMEOUT_CYCLES);

  logic [2:0]    state;
  logic          readyReg;
  logic [IW-1:0] wordIndex;
  logic [IW-1:0] wordCount;
  logic [IW-1:0] nextIndex;
  logic [7:0]    checksum;
  logic [TW-1:0] timer;
  logic          accept;
  logic          active;
  logic          expired;

  // The sender must hold its byte through the write-strobe cycle.
  assign byteReady = readyReg && !writeEnable;
  assign accept    = byteValid && byteReady;
  assign nextIndex = wordIndex + IW'(1);

  assign active = (state == COUNT) || (state == HIGH) ||
                  (state == LOW)   || (state == CHECK);

  assign expired = active && (timer == TLIMIT) && !accept;

  always_ff @(posedge clock or negedge isResetN) begin
    if (!isResetN) begin
      state        <= IDLE;
      readyReg     <= 1'b0;
      writeEnable  <= 1'b0;
      writeAddress <= '0;
      writeData    <= '0;
      cpuReset     <= 1'b1;
      loadDone     <= 1'b0;
      loadError    <= 1'b0;
      wordIndex    <= '0;
      wordCount    <= '0;
      checksum     <= '0;
      timer        <= '0;
    end else begin
      readyReg    <= 1'b1;
      writeEnable <= 1'b0;

      if (accept)
        timer <= '0;
      else if (active && timer != TLIMIT)
        timer <= timer + TW'(1);

      if (writeEnable) begin
        wordIndex <= nextIndex;
        state     <= (nextIndex == wordCount) ? CHECK : HIGH;
      end else if (expired) begin
        state     <= ERROR;
        loadError <= 1'b1;
        cpuReset  <= 1'b1;
      end else if (accept) begin
        unique case (state)
          IDLE, DONE, ERROR: begin
            if (byteData == START) begin
              state     <= COUNT;
              cpuReset  <= 1'b1;
              loadDone  <= 1'b0;
              loadError <= 1'b0;
              wordIndex <= '0;
              checksum  <= '0;
            end
          end
          COUNT: begin
            if (byteData == 8'h00) begin
              wordCount <= '0;
              state     <= CHECK;
            end else if (32'(byteData) > MAX_WORDS) begin
              state     <= ERROR;
              loadError <= 1'b1;
              cpuReset  <= 1'b1;
            end else begin
              wordCount <= IW'(byteData);
              state     <= HIGH;
            end
          end
          HIGH: begin
            writeData[INSTRUCTION_WIDTH-1 -: 8] <= byteData;
            checksum <= checksum ^ byteData;
            state    <= LOW;
          end
          LOW: begin
            writeData[7:0] <= byteData;
            checksum       <= checksum ^ byteData;
            writeAddress   <= wordIndex[PC_WIDTH-1:0];
            writeEnable    <= 1'b1;
          end
          CHECK: begin
            if (byteData == checksum) begin
              state    <= DONE;
              loadDone <= 1'b1;
              cpuReset <= 1'b0;
            end else begin
              state     <= ERROR;
              loadError <= 1'b1;
              cpuReset  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The module SHALL have parameter INSTRUCTION_WIDTH, default 16, the instruction word width; only 16 is supported.
REQ-002 The module SHALL have parameter PC_WIDTH, default 8, the instruction-memory address width.
REQ-003 The module SHALL have parameter TIMEOUT_CYCLES, default 1000, the maximum idle gap between bytes inside a frame.
REQ-004 The module SHALL have port clock, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port isResetN, input, 1, the reset: asynchronous assert, active-low.
REQ-006 The module SHALL have port byteData, input, 8, the serial-link byte.
REQ-007 The module SHALL have port byteValid, input, 1, which is high when byteData is valid.
REQ-008 The module SHALL have port byteReady, output, 1, which is high when the loader accepts a byte; a byte transfers when byteValid && byteReady.
REQ-009 The module SHALL have port writeEnable, output, 1, the instruction-memory write strobe.
REQ-010 The module SHALL have port writeAddress, output, PC_WIDTH, the instruction-memory word address.
REQ-011 The module SHALL have port writeData, output, INSTRUCTION_WIDTH, the instruction word.
REQ-012 The module SHALL have port cpuReset, output, 1, the active-high hold-in-reset driving the CPU reset input.
REQ-013 The module SHALL have port loadDone, output, 1, which is high while a verified program is resident.
REQ-014 The module SHALL have port loadError, output, 1, which is high after a failed frame.

Function
REQ-015 The loader SHALL accept this frame format: start byte 0xA5, count byte N in words, 2N data bytes (high byte first per word), then a checksum byte equal to the XOR of all 2N data bytes.
REQ-016 The loader SHALL implement states IDLE, COUNT, HIGH, LOW, CHECK, DONE and ERROR.
REQ-017 In IDLE, DONE or ERROR, accepting 0xA5 SHALL move the loader to COUNT, set cpuReset=1, clear loadDone and loadError, and clear the word index and checksum; any other byte SHALL be ignored.
REQ-018 In COUNT, N=0 SHALL move to CHECK; N>2^PC_WIDTH SHALL move to ERROR; any other N SHALL be latched and the loader SHALL move to HIGH.
REQ-019 In HIGH, the loader SHALL latch the byte as writeData[15:8] and move to LOW.
REQ-020 In LOW, the loader SHALL form the word and, on the next cycle, pulse writeEnable for exactly 1 cycle with writeAddress = the word index and writeData = {high, low}.
REQ-021 After that write, the loader SHALL increment the word index; if the index equals N it SHALL move to CHECK, otherwise to HIGH.
REQ-022 Every data byte SHALL be XORed into the running checksum on acceptance.
REQ-023 In CHECK, a received byte equal to the checksum SHALL move the loader to DONE, setting loadDone=1 and cpuReset=0 on the same edge; any mismatch SHALL move it to ERROR with loadError=1 and cpuReset=1.
REQ-024 byteReady SHALL be 1 in every state except the single cycle in which writeEnable is high; a byte presented during that cycle SHALL be held by the sender and SHALL NOT be lost.
REQ-025 The timeout counter SHALL reset on each accepted byte and SHALL count only in COUNT, HIGH, LOW and CHECK.
REQ-026 When the timeout counter reaches TIMEOUT_CYCLES, the loader SHALL move to ERROR; the counter SHALL saturate and never wrap.
REQ-027 writeEnable SHALL never assert outside HIGH/LOW processing, and at most N writes SHALL occur per frame.
REQ-028 A 0xA5 byte received in HIGH, LOW or CHECK SHALL be treated as data, not as a restart.
REQ-029 In ERROR, cpuReset SHALL remain 1 until a subsequent frame succeeds.

Reset
REQ-030 Asserting isResetN=0 SHALL, asynchronously, force state=IDLE, cpuReset=1, writeEnable=0, loadDone=0, loadError=0, byteReady=0, writeAddress=0, writeData=0, word index=0, checksum=0 and timeout counter=0.
REQ-031 After isResetN deasserts, byteReady SHALL rise on the first clock edge.
REQ-032 Reset asserted mid-frame SHALL abandon the frame without issuing any further write.
REQ-033 The CPU SHALL stay held in reset from power-up until the first successful load.

Verification
REQ-034 The bench SHALL send A5 02 12 34 AB CD 40 and check writes (0,0x1234) and (1,0xABCD), then loadDone=1 and cpuReset=0 one cycle after the checksum byte is accepted.
REQ-035 The bench SHALL send the same frame with checksum 41 and check loadError=1, cpuReset=1, loadDone=0, and that exactly 2 writes occurred.
REQ-036 The bench SHALL send A5 00 00 and check no writes and loadDone=1.
REQ-037 The bench SHALL send A5 01 12, idle TIMEOUT_CYCLES cycles, and check ERROR with no write; then send a valid frame and check DONE.
REQ-038 The bench SHALL send bytes 00 FF 13 before A5 and check they are ignored with no state change.
REQ-039 The bench SHALL pulse isResetN low after A5 02 12 34 and check all outputs take their reset values immediately, and that a fresh frame then loads from address 0.
